// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer control/status bundle.
// Inputs: armed, time_match, snooze_btn, dismiss_btn (levels, already synchronised).
// Outputs: state, ringing, beep, display_on, snooze_count.
interface alarm_sequencer_if;
  logic       armed;
  logic       time_match;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic [1:0] state;
  logic       ringing;
  logic       beep;
  logic       display_on;
  logic [2:0] snooze_count;

  // Controller / stimulus side: drives requests, observes status.
  modport master (
    output armed, time_match, snooze_btn, dismiss_btn,
    input  state, ringing, beep, display_on, snooze_count
  );

  // Sequencer side.
  modport slave (
    input  armed, time_match, snooze_btn, dismiss_btn,
    output state, ringing, beep, display_on, snooze_count
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Purpose: alarm clock ring/snooze/dismiss sequencer driven by a 1 Hz clock.
// Latency: all outputs decode registered state; input effects appear one clk_1hz edge later.
// Backpressure: none; button presses are edge events and are ignored where not meaningful.
//
// Ports: clk_1hz (sole clock), reset (async, active-high), bus (alarm_sequencer_if.slave):
//   armed/time_match levels, snooze_btn/dismiss_btn levels (rising edge = press),
//   state (IDLE=0 RING=1 SNOOZE=2 LOCKOUT=3), ringing, beep, display_on, snooze_count.
module alarm_sequencer #(
  parameter int RING_SECONDS   = 300,
  parameter int SNOOZE_SECONDS = 540,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic              clk_1hz,
  input  logic              reset,
  alarm_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [9:0] RING_LOAD   = 10'(RING_SECONDS - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECONDS - 1);
  localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);

  state_t     cur_state;
  logic [9:0] timer;          // shared by RING and SNOOZE
  logic       phase;          // toggles each RING cycle; drives the beep/blank cadence
  logic [2:0] snooze_count;
  logic       snooze_q;
  logic       dismiss_q;

  logic snooze_press;
  logic dismiss_press;

  assign snooze_press  = bus.snooze_btn  & ~snooze_q;
  assign dismiss_press = bus.dismiss_btn & ~dismiss_q;

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      cur_state    <= IDLE;
      timer        <= '0;
      phase        <= 1'b0;
      snooze_count <= '0;
      snooze_q     <= 1'b0;
      dismiss_q    <= 1'b0;
    end else begin
      snooze_q  <= bus.snooze_btn;
      dismiss_q <= bus.dismiss_btn;

      case (cur_state)
        IDLE: begin
          if (bus.armed && bus.time_match) begin
            cur_state <= RING;
            timer     <= RING_LOAD;
            phase     <= 1'b1;
          end
        end

        RING: begin
          // Disarm and dismiss outrank everything; a snooze at the count
          // limit falls through to the normal countdown.
          if (!bus.armed || dismiss_press) begin
            cur_state    <= LOCKOUT;
            timer        <= '0;
            phase        <= 1'b0;
            snooze_count <= '0;
          end else if (snooze_press && (snooze_count < MAX_CNT)) begin
            cur_state    <= SNOOZE;
            timer        <= SNOOZE_LOAD;
            snooze_count <= snooze_count + 3'd1;
          end else if (timer == 10'd0) begin
            cur_state    <= LOCKOUT;
            phase        <= 1'b0;
            snooze_count <= '0;
          end else begin
            timer <= timer - 10'd1;
            phase <= ~phase;
          end
        end

        SNOOZE: begin
          if (!bus.armed || dismiss_press) begin
            cur_state    <= LOCKOUT;
            timer        <= '0;
            phase        <= 1'b0;
            snooze_count <= '0;
          end else if (timer == 10'd0) begin
            // Return to ringing without re-checking time_match.
            cur_state <= RING;
            timer     <= RING_LOAD;
            phase     <= 1'b1;
          end else begin
            timer <= timer - 10'd1;
          end
        end

        LOCKOUT: begin
          // Wait out the match window so it cannot retrigger.
          if (!bus.time_match) begin
            cur_state <= IDLE;
          end
        end

        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.state        = cur_state;
  assign bus.ringing      = (cur_state == RING);
  assign bus.beep         = (cur_state == RING) & phase;
  assign bus.display_on   = ~((cur_state == RING) & ~phase);
  assign bus.snooze_count = snooze_count;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING_SECONDS=4, SNOOZE_SECONDS=3, MAX_SNOOZE=2.
// Expected outputs are queued as stimulus is applied and checked after the next edge.
module tb_alarm_sequencer;

  logic clk_1hz;
  logic reset;

  alarm_sequencer_if bus_if ();

  alarm_sequencer #(
    .RING_SECONDS  (4),
    .SNOOZE_SECONDS(3),
    .MAX_SNOOZE    (2)
  ) dut (
    .clk_1hz(clk_1hz),
    .reset  (reset),
    .bus    (bus_if)
  );

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  typedef struct packed {
    logic [1:0] st;
    logic       rng;
    logic       bp;
    logic       dn;
    logic [2:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RING = 2'd1, S_SNZ = 2'd2, S_LOCK = 2'd3;

  task automatic cmp(input string tag, input string fld, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, fld, obs, expv);
    end
  endtask

  task automatic want(input string tag, input logic [1:0] st, input logic bp,
                      input logic dn, input logic [2:0] cnt);
    exp_t e;
    e.st  = st;
    e.rng = (st == S_RING);
    e.bp  = bp;
    e.dn  = dn;
    e.cnt = cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "state",        int'(bus_if.state),        int'(e.st));
      cmp(t, "ringing",      int'(bus_if.ringing),      int'(e.rng));
      cmp(t, "beep",         int'(bus_if.beep),         int'(e.bp));
      cmp(t, "display_on",   int'(bus_if.display_on),   int'(e.dn));
      cmp(t, "snooze_count", int'(bus_if.snooze_count), int'(e.cnt));
    end
  endtask

  // Queue the expectation for the next edge, then sample #1 after it.
  task automatic step(input string tag, input logic [1:0] st, input logic bp,
                      input logic dn, input logic [2:0] cnt);
    want(tag, st, bp, dn, cnt);
    @(posedge clk_1hz);
    #1;
    check_now();
  endtask

  initial begin
    reset                 = 1'b1;
    bus_if.armed          = 1'b0;
    bus_if.time_match     = 1'b0;
    bus_if.snooze_btn     = 1'b0;
    bus_if.dismiss_btn    = 1'b0;
    #2;
    want("reset", S_IDLE, 1'b0, 1'b1, 3'd0);
    check_now();
    @(posedge clk_1hz);
    #1;
    reset = 1'b0;

    // Plain ring with no presses: 4 RING cycles, beep/display 1,0,1,0.
    bus_if.armed      = 1'b1;
    bus_if.time_match = 1'b1;
    step("ring_c1", S_RING, 1'b1, 1'b1, 3'd0);
    step("ring_c2", S_RING, 1'b0, 1'b0, 3'd0);
    step("ring_c3", S_RING, 1'b1, 1'b1, 3'd0);
    step("ring_c4", S_RING, 1'b0, 1'b0, 3'd0);
    step("ring_lock", S_LOCK, 1'b0, 1'b1, 3'd0);
    step("lock_hold", S_LOCK, 1'b0, 1'b1, 3'd0);
    bus_if.time_match = 1'b0;
    step("lock_idle", S_IDLE, 1'b0, 1'b1, 3'd0);
    step("idle_hold", S_IDLE, 1'b0, 1'b1, 3'd0);

    // Snooze in the 2nd RING cycle, then a full ring after the snooze.
    bus_if.time_match = 1'b1;
    step("s1_ring1", S_RING, 1'b1, 1'b1, 3'd0);
    bus_if.time_match = 1'b0;
    step("s1_ring2", S_RING, 1'b0, 1'b0, 3'd0);
    bus_if.snooze_btn = 1'b1;
    step("s1_snz1", S_SNZ, 1'b0, 1'b1, 3'd1);
    bus_if.snooze_btn = 1'b0;
    step("s1_snz2", S_SNZ, 1'b0, 1'b1, 3'd1);
    step("s1_snz3", S_SNZ, 1'b0, 1'b1, 3'd1);
    step("s1_rr1", S_RING, 1'b1, 1'b1, 3'd1);
    step("s1_rr2", S_RING, 1'b0, 1'b0, 3'd1);
    step("s1_rr3", S_RING, 1'b1, 1'b1, 3'd1);
    step("s1_rr4", S_RING, 1'b0, 1'b0, 3'd1);
    step("s1_lock", S_LOCK, 1'b0, 1'b1, 3'd0);
    step("s1_idle", S_IDLE, 1'b0, 1'b1, 3'd0);

    // Three snoozes: two honoured, third ignored at the limit.
    bus_if.time_match = 1'b1;
    step("s3_ring", S_RING, 1'b1, 1'b1, 3'd0);
    bus_if.time_match = 1'b0;
    bus_if.snooze_btn = 1'b1;
    step("s3_snzA", S_SNZ, 1'b0, 1'b1, 3'd1);
    bus_if.snooze_btn = 1'b0;
    step("s3_snzA2", S_SNZ, 1'b0, 1'b1, 3'd1);
    step("s3_snzA3", S_SNZ, 1'b0, 1'b1, 3'd1);
    step("s3_ringB", S_RING, 1'b1, 1'b1, 3'd1);
    bus_if.snooze_btn = 1'b1;
    step("s3_snzB", S_SNZ, 1'b0, 1'b1, 3'd2);
    bus_if.snooze_btn = 1'b0;
    step("s3_snzB2", S_SNZ, 1'b0, 1'b1, 3'd2);
    step("s3_snzB3", S_SNZ, 1'b0, 1'b1, 3'd2);
    step("s3_ringC", S_RING, 1'b1, 1'b1, 3'd2);
    bus_if.snooze_btn = 1'b1;
    step("s3_ignored", S_RING, 1'b0, 1'b0, 3'd2);
    bus_if.snooze_btn = 1'b0;
    step("s3_ringC3", S_RING, 1'b1, 1'b1, 3'd2);
    step("s3_ringC4", S_RING, 1'b0, 1'b0, 3'd2);
    step("s3_lock", S_LOCK, 1'b0, 1'b1, 3'd0);
    step("s3_idle", S_IDLE, 1'b0, 1'b1, 3'd0);

    // Simultaneous snooze + dismiss in RING: dismiss wins.
    bus_if.time_match = 1'b1;
    step("sd_ring", S_RING, 1'b1, 1'b1, 3'd0);
    bus_if.time_match = 1'b0;
    bus_if.snooze_btn = 1'b1;
    step("sd_snz", S_SNZ, 1'b0, 1'b1, 3'd1);
    bus_if.snooze_btn = 1'b0;
    step("sd_snz2", S_SNZ, 1'b0, 1'b1, 3'd1);
    step("sd_snz3", S_SNZ, 1'b0, 1'b1, 3'd1);
    step("sd_ring2", S_RING, 1'b1, 1'b1, 3'd1);
    bus_if.snooze_btn  = 1'b1;
    bus_if.dismiss_btn = 1'b1;
    step("sd_lock", S_LOCK, 1'b0, 1'b1, 3'd0);
    bus_if.snooze_btn  = 1'b0;
    bus_if.dismiss_btn = 1'b0;
    step("sd_idle", S_IDLE, 1'b0, 1'b1, 3'd0);

    // Disarm during SNOOZE; re-arm inside the match window must not retrigger.
    bus_if.time_match = 1'b1;
    step("da_ring", S_RING, 1'b1, 1'b1, 3'd0);
    bus_if.snooze_btn = 1'b1;
    step("da_snz", S_SNZ, 1'b0, 1'b1, 3'd1);
    bus_if.snooze_btn = 1'b0;
    bus_if.armed      = 1'b0;
    step("da_lock", S_LOCK, 1'b0, 1'b1, 3'd0);
    bus_if.armed = 1'b1;
    step("da_rearm1", S_LOCK, 1'b0, 1'b1, 3'd0);
    step("da_rearm2", S_LOCK, 1'b0, 1'b1, 3'd0);
    bus_if.time_match = 1'b0;
    step("da_idle", S_IDLE, 1'b0, 1'b1, 3'd0);
    bus_if.armed      = 1'b0;
    bus_if.time_match = 1'b1;
    step("unarmed_idle", S_IDLE, 1'b0, 1'b1, 3'd0);

    // Asynchronous reset mid-RING, then immediate re-entry on release.
    bus_if.armed = 1'b1;
    step("rst_ring1", S_RING, 1'b1, 1'b1, 3'd0);
    step("rst_ring2", S_RING, 1'b0, 1'b0, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    want("rst_async", S_IDLE, 1'b0, 1'b1, 3'd0);
    check_now();
    step("rst_held", S_IDLE, 1'b0, 1'b1, 3'd0);
    reset = 1'b0;
    step("rst_reenter", S_RING, 1'b1, 1'b1, 3'd0);

    // Dismiss alone in RING.
    bus_if.dismiss_btn = 1'b1;
    step("dis_lock", S_LOCK, 1'b0, 1'b1, 3'd0);
    bus_if.dismiss_btn = 1'b0;
    bus_if.time_match  = 1'b0;
    step("dis_idle", S_IDLE, 1'b0, 1'b1, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
